// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl
// ---------------------------------------------------------------------------
// Frame scheduler for the convolution PE group. On start it raster-scans one
// IMG_W x IMG_H image from the image RAM. It tags each returned pixel with its
// row/col for the line buffer. It raises win_valid only when a full KxK
// window exists, and it counts returning results into sequential
// output-buffer addresses.
//
// Optional feature: define CONV_CTRL_WDOG_EN to enable the DRAIN watchdog.
// If no result_valid arrives for WDOG_CYC consecutive DRAIN cycles, the
// frame is aborted: err is set and done is pulsed. Without the macro, err is
// tied low and DRAIN waits indefinitely.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                1-cycle frame request, accepted only in IDLE
//   hold                 pauses new image reads while high
//   img_rd_en/_addr      image RAM read strobe / raster address (1-cycle RAM)
//   pix_valid/_row/_col  RAM data valid + its row/col (line-buffer shift)
//   win_valid            PE group valid_in (complete KxK window)
//   result_valid         PE group result strobe
//   out_wr_en/out_addr   output buffer write strobe / sequential address
//   busy, done, err      frame in progress / completion pulse / sticky wdog
// ---------------------------------------------------------------------------
module conv_layer_ctrl #(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int K        = 5,
   parameter int ADDR_W   = 10,
   parameter int OADDR_W  = 10,
   parameter int WDOG_CYC = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               hold,
   output logic               img_rd_en,
   output logic [ADDR_W-1:0]  img_rd_addr,
   output logic               pix_valid,
   output logic [4:0]         pix_row,
   output logic [4:0]         pix_col,
   output logic               win_valid,
   input  logic               result_valid,
   output logic               out_wr_en,
   output logic [OADDR_W-1:0] out_addr,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int NWIN = (IMG_W - K + 1) * (IMG_H - K + 1);

   // Elaboration-time sanity checks on the parameter set.
   if (NPIX > (1 << ADDR_W)) begin : g_chk_addr
      $error("conv_layer_ctrl: ADDR_W too small for IMG_W*IMG_H");
   end
   if (NWIN > (1 << OADDR_W)) begin : g_chk_oaddr
      $error("conv_layer_ctrl: OADDR_W too small for window count");
   end
   if (IMG_W > 32 || IMG_H > 32 || K > IMG_W || K > IMG_H) begin : g_chk_dims
      $error("conv_layer_ctrl: image/kernel dimensions out of range");
   end
   if (WDOG_CYC < 1) begin : g_chk_wdog
      $error("conv_layer_ctrl: WDOG_CYC must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // Pixel tag travelling one cycle behind the read (matches RAM latency).
   typedef struct packed {
      logic       vld;
      logic [4:0] row;
      logic [4:0] col;
   } pix_tag_t;

   state_t             state, state_nxt;
   logic [4:0]         row, col;
   logic [ADDR_W-1:0]  rd_addr;
   logic [OADDR_W-1:0] res_cnt;
   pix_tag_t           pix;
   logic               win_q;

   logic start_ok, rd_fire, last_rd, res_fire, all_res, wdog_to;

   assign start_ok = (state == IDLE) && start;
   assign rd_fire  = (state == RUN) && !hold;
   assign last_rd  = (rd_addr == ADDR_W'(NPIX - 1));
   assign all_res  = (res_cnt == OADDR_W'(NWIN));
   // Results are only counted inside a frame and never past the window total.
   assign res_fire = result_valid && (state != IDLE) && !all_res;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN:   if (rd_fire && last_rd) state_nxt = DRAIN;
         DRAIN: if (all_res || wdog_to) begin
                   done      = 1'b1;
                   state_nxt = IDLE;
                end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- read address / raster position ----------------
   // The address is a running counter; it always equals row*IMG_W+col, so
   // no multiplier is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row     <= '0;
         col     <= '0;
         rd_addr <= '0;
      end else if (start_ok) begin
         row     <= '0;
         col     <= '0;
         rd_addr <= '0;
      end else if (rd_fire) begin
         rd_addr <= rd_addr + 1'b1;
         if (col == 5'(IMG_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // ---------------- pixel tag + window detect ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix   <= '0;
         win_q <= 1'b0;
      end else begin
         pix   <= '{vld: rd_fire, row: row, col: col};
         win_q <= pix.vld && (pix.row >= 5'(K - 1)) && (pix.col >= 5'(K - 1));
      end
   end

   // ---------------- result counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        res_cnt <= '0;
      else if (start_ok) res_cnt <= '0;
      else if (res_fire) res_cnt <= res_cnt + 1'b1;
   end

   // ---------------- optional drain watchdog ----------------
`ifdef CONV_CTRL_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);

   logic [WD_W-1:0] wdog_cnt;
   logic            err_q;

   // Counts consecutive DRAIN cycles without a result; saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             wdog_cnt <= '0;
      else if (state != DRAIN || result_valid) wdog_cnt <= '0;
      else if (!wdog_to)                      wdog_cnt <= wdog_cnt + 1'b1;
   end

   assign wdog_to = (state == DRAIN) && (wdog_cnt == WD_W'(WDOG_CYC));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   err_q <= 1'b0;
      else if (start_ok)            err_q <= 1'b0;
      else if (wdog_to && !all_res) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign wdog_to = 1'b0;
   assign err     = 1'b0;
`endif

   // ---------------- outputs ----------------
   assign img_rd_en   = rd_fire;
   assign img_rd_addr = rd_addr;
   assign pix_valid   = pix.vld;
   assign pix_row     = pix.row;
   assign pix_col     = pix.col;
   assign win_valid   = win_q;
   assign out_wr_en   = res_fire;
   assign out_addr    = res_fire ? res_cnt : '0;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_conv_layer_ctrl.sv
module tb_conv_layer_ctrl;
   localparam int IMG_W = 28, IMG_H = 28, K = 5;
   localparam int ADDR_W = 10, OADDR_W = 10, WDOG_CYC = 64;
   localparam int NPIX = IMG_W * IMG_H;
   localparam int NWIN = (IMG_W - K + 1) * (IMG_H - K + 1);

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
   logic inj = 1'b0, drop_en = 1'b0;
   logic result_valid;
   logic img_rd_en, pix_valid, win_valid, out_wr_en, busy, done, err;
   logic [ADDR_W-1:0]  img_rd_addr;
   logic [OADDR_W-1:0] out_addr;
   logic [4:0]         pix_row, pix_col;

   logic [2:0] pe_pipe;
   int         pe_cnt;
   int         total = 0, bad = 0;

   conv_layer_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W),
                     .OADDR_W(OADDR_W), .WDOG_CYC(WDOG_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
      .pix_valid(pix_valid), .pix_row(pix_row), .pix_col(pix_col),
      .win_valid(win_valid), .result_valid(result_valid),
      .out_wr_en(out_wr_en), .out_addr(out_addr),
      .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   // PE group model: echoes win_valid 3 cycles later; optionally drops the
   // last two results of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_pipe <= '0;
         pe_cnt  <= 0;
      end else begin
         pe_pipe <= {pe_pipe[1:0], win_valid};
         if (start)           pe_cnt <= 0;
         else if (pe_pipe[2]) pe_cnt <= pe_cnt + 1;
      end
   end

   assign result_valid = inj || (pe_pipe[2] && !(drop_en && pe_cnt >= NWIN - 2));

   // Runs one frame from a start pulse to done, scoreboarding reads, pixel
   // tags, windows and writes.
   task automatic run_frame(input int hold_at, input int hold_len,
                            input int restart_at, input bit drop, input bit exp_err);
      int rq[$], cq[$], oq[$];
      int rd_cnt = 0, wins = 0, writes = 0, dones = 0, last_wr = -100;
      int hold_left = 0, exp_wr, exp_done, r, c, e;
      bit exp_win = 0, fin = 0, held = 0, restarted = 0;
      logic [4:0] prev_row = '0, prev_col = '0;
      exp_wr  = drop ? NWIN - 2 : NWIN;
      drop_en = drop;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      total++;
      if (busy !== 1'b1 || err !== 1'b0 || img_rd_en !== 1'b1) begin
         bad++; $display("FAIL frame_start busy=%b err=%b rd_en=%b exp 1,0,1", busy, err, img_rd_en);
      end
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         if (img_rd_en) begin
            total++;
            if (img_rd_addr !== ADDR_W'(rd_cnt)) begin
               bad++; $display("FAIL rd_addr got=%0d exp=%0d", img_rd_addr, rd_cnt);
            end
            rq.push_back(rd_cnt / IMG_W);
            cq.push_back(rd_cnt % IMG_W);
            rd_cnt++;
         end
         if (hold) begin
            total++;
            if (img_rd_en !== 1'b0) begin
               bad++; $display("FAIL hold_read rd_en=%b exp 0", img_rd_en);
            end
         end
         total++;
         if (win_valid !== exp_win) begin
            bad++; $display("FAIL win_valid got=%b exp=%b cyc=%0d", win_valid, exp_win, cyc);
         end
         if (win_valid) begin
            if (wins == 0) begin
               total++;
               if (prev_row !== 5'd4 || prev_col !== 5'd4) begin
                  bad++; $display("FAIL first_win row=%0d col=%0d exp 4,4", prev_row, prev_col);
               end
            end
            if (wins < exp_wr) oq.push_back(wins);
            wins++;
         end
         exp_win = 1'b0;
         if (pix_valid) begin
            total++;
            if (rq.size() == 0) begin
               bad++; $display("FAIL pix_spurious row=%0d col=%0d exp none", pix_row, pix_col);
            end else begin
               r = rq.pop_front();
               c = cq.pop_front();
               if (pix_row !== 5'(r) || pix_col !== 5'(c)) begin
                  bad++; $display("FAIL pix_tag got=%0d,%0d exp=%0d,%0d", pix_row, pix_col, r, c);
               end
               exp_win = (r >= K - 1) && (c >= K - 1);
            end
         end
         prev_row = pix_row;
         prev_col = pix_col;
         if (out_wr_en) begin
            total++;
            if (oq.size() == 0) begin
               bad++; $display("FAIL wr_spurious addr=%0d exp none", out_addr);
            end else begin
               e = oq.pop_front();
               if (out_addr !== OADDR_W'(e)) begin
                  bad++; $display("FAIL out_addr got=%0d exp=%0d", out_addr, e);
               end
            end
            writes++;
            last_wr = cyc;
         end
         if (done) begin
            dones++;
            exp_done = drop ? last_wr + WDOG_CYC + 1 : last_wr + 1;
            total++;
            if (cyc != exp_done) begin
               bad++; $display("FAIL done_time got=%0d exp=%0d", cyc, exp_done);
            end
            fin = 1'b1;
         end
         // Drive inputs for the next cycle.
         if (!held && hold_at >= 0 && rd_cnt == hold_at) begin
            held = 1'b1; hold_left = hold_len;
         end
         if (hold_left > 0) begin hold = 1'b1; hold_left--; end
         else hold = 1'b0;
         if (start) start = 1'b0;
         else if (!restarted && restart_at >= 0 && rd_cnt == restart_at) begin
            start = 1'b1; restarted = 1'b1;
         end
         @(negedge clk);
      end
      hold = 1'b0; start = 1'b0;
      total++;
      if (!fin) begin bad++; $display("FAIL frame_timeout done=%0d exp 1", dones); end
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== exp_err) begin
         bad++; $display("FAIL frame_end busy=%b done=%b err=%b exp 0,0,%b", busy, done, err, exp_err);
      end
      total++;
      if (rd_cnt != NPIX || rq.size() != 0) begin
         bad++; $display("FAIL read_count got=%0d exp=%0d", rd_cnt, NPIX);
      end
      total++;
      if (wins != NWIN) begin bad++; $display("FAIL win_count got=%0d exp=%0d", wins, NWIN); end
      total++;
      if (writes != exp_wr || oq.size() != 0) begin
         bad++; $display("FAIL write_count got=%0d exp=%0d", writes, exp_wr);
      end
      total++;
      if (dones != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", dones); end
      drop_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({img_rd_en, img_rd_addr, pix_valid, pix_row, pix_col, win_valid,
           out_wr_en, out_addr, busy, done, err} !== '0) begin
         bad++; $display("FAIL reset_outputs rd_en=%b busy=%b pix_valid=%b addr=%0d exp all 0",
                         img_rd_en, busy, pix_valid, img_rd_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || img_rd_en !== 1'b0) begin
         bad++; $display("FAIL post_reset_idle busy=%b rd_en=%b exp 0,0", busy, img_rd_en);
      end
   endtask

   task automatic test_basic_frame();
      run_frame(-1, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_hold();
      run_frame(12 * IMG_W + 7, 10, -1, 1'b0, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_frame(-1, 0, 300, 1'b0, 1'b0);
   endtask

   task automatic test_idle_inject();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) inj = 1'b1;
         #1;
         total++;
         if (out_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_inject wr_en=%b busy=%b done=%b exp 0,0,0", out_wr_en, busy, done);
         end
      end
      @(negedge clk) inj = 1'b0;
      // The following frame must still write from address 0.
      run_frame(-1, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int rd = 0, n = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (rd < 400 && n < 2000) begin
         if (img_rd_en) rd++;
         if (done) begin bad++; total++; $display("FAIL mid_done got=1 exp=0"); end
         if (rd < 400) @(negedge clk);
         n++;
      end
      total++;
      if (rd != 400) begin bad++; $display("FAIL mid_reach got=%0d exp=400", rd); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({img_rd_en, img_rd_addr, pix_valid, pix_row, pix_col, win_valid,
           out_wr_en, out_addr, busy, done, err} !== '0) begin
         bad++; $display("FAIL mid_reset_outputs rd_en=%b busy=%b pix_valid=%b win=%b exp all 0",
                         img_rd_en, busy, pix_valid, win_valid);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL mid_after busy=%b done=%b exp 0,0", busy, done);
      end
      run_frame(-1, 0, -1, 1'b0, 1'b0);
   endtask

`ifdef CONV_CTRL_WDOG_EN
   task automatic test_watchdog();
      run_frame(-1, 0, -1, 1'b1, 1'b1);
      run_frame(-1, 0, -1, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_hold();
      test_start_ignored();
      test_idle_inject();
      test_reset_mid();
`ifdef CONV_CTRL_WDOG_EN
      test_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
